// File: rtl/pokey_pkg.sv
// Shared POKEY definitions: register map, AUDCTL bit positions and counter reload helpers.
package pokey_pkg;

    localparam logic [3:0] ADDR_AUDF1  = 4'd0;
    localparam logic [3:0] ADDR_AUDC1  = 4'd1;
    localparam logic [3:0] ADDR_AUDF2  = 4'd2;
    localparam logic [3:0] ADDR_AUDC2  = 4'd3;
    localparam logic [3:0] ADDR_AUDF3  = 4'd4;
    localparam logic [3:0] ADDR_AUDC3  = 4'd5;
    localparam logic [3:0] ADDR_AUDF4  = 4'd6;
    localparam logic [3:0] ADDR_AUDC4  = 4'd7;
    localparam logic [3:0] ADDR_AUDCTL = 4'd8;
    localparam logic [3:0] ADDR_STIMER = 4'd9;

    localparam int CLK15  = 0;
    localparam int HP2    = 1;
    localparam int HP1    = 2;
    localparam int JOIN34 = 3;
    localparam int JOIN12 = 4;
    localparam int FAST3  = 5;
    localparam int FAST1  = 6;
    localparam int POLY9  = 7;

    typedef logic [8:0]  cnt_t;
    typedef logic [16:0] jcnt_t;

    // A channel on the machine clock needs three extra counts to match real POKEY timing.
    function automatic cnt_t single_reload(input logic [7:0] audf, input logic fast);
        single_reload = {1'b0, audf} + (fast ? 9'd3 : 9'd0);
    endfunction

    function automatic jcnt_t joined_reload(input logic [7:0] hi, input logic [7:0] lo,
                                            input logic fast);
        joined_reload = {1'b0, hi, lo} + (fast ? 17'd6 : 17'd0);
    endfunction

endpackage

// File: rtl/pokey_timer_channel.sv
// One POKEY timer slice: down-counter with reload priority and zero detect.
module pokey_timer_channel
    import pokey_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       dec_i,
    input  logic       wide_i,
    input  logic [8:0] reload_val_i,
    output logic       zero_o
);

    cnt_t count_q;
    cnt_t count_d;

    // Narrow mode is the low byte of a joined pair: wraps within 8 bits.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = reload_val_i;
        end else if (dec_i) begin
            if (wide_i) begin
                count_d = count_q - 9'd1;
            end else begin
                count_d = {1'b0, count_q[7:0] - 8'd1};
            end
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 9'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = wide_i ? (count_q == 9'd0) : (count_q[7:0] == 8'd0);

endmodule

// File: rtl/pokey_timer_ctrl.sv
// POKEY audio timer control: register file, tick selection, 16-bit channel joining and STIMER resync.
module pokey_timer_ctrl
    import pokey_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        enable_64,
    input  logic        enable_15,
    input  logic        wr_en,
    input  logic [3:0]  addr,
    input  logic [7:0]  wr_data,
    output logic [3:0]  pulse,
    output logic [11:0] noise_select,
    output logic [3:0]  vol_only,
    output logic [15:0] volume,
    output logic        sync_reset,
    output logic [7:0]  audctl
);

    logic [3:0][7:0]  audf_q, audf_d, audc_q, audc_d;
    logic [7:0]       audctl_q, audctl_d;
    logic             stimer_pending_q, stimer_pending_d, stimer_wr_s;
    logic             base_s, stim_s;
    logic [3:0]       tick_s, ev_s, zero_s, load_s, dec_s, wide_s, pulse_s;
    logic [3:0][8:0]  rv_s;
    logic [1:0]       join_s, fast_s, jz_s, lo_under_s;
    logic [1:0][16:0] jrv_s;

    always_comb begin
        audf_d      = audf_q;
        audc_d      = audc_q;
        audctl_d    = audctl_q;
        stimer_wr_s = 1'b0;
        if (wr_en) begin
            case (addr)
                ADDR_AUDF1:  audf_d[0]   = wr_data;
                ADDR_AUDC1:  audc_d[0]   = wr_data;
                ADDR_AUDF2:  audf_d[1]   = wr_data;
                ADDR_AUDC2:  audc_d[1]   = wr_data;
                ADDR_AUDF3:  audf_d[2]   = wr_data;
                ADDR_AUDC3:  audc_d[2]   = wr_data;
                ADDR_AUDF4:  audf_d[3]   = wr_data;
                ADDR_AUDC4:  audc_d[3]   = wr_data;
                ADDR_AUDCTL: audctl_d    = wr_data;
                ADDR_STIMER: stimer_wr_s = 1'b1;
                default:     stimer_wr_s = 1'b0;
            endcase
        end else begin
            stimer_wr_s = 1'b0;
        end
    end

    // A STIMER write wins over consumption so a write on a ce edge waits for the next ce.
    always_comb begin
        if (stimer_wr_s) begin
            stimer_pending_d = 1'b1;
        end else if (ce) begin
            stimer_pending_d = 1'b0;
        end else begin
            stimer_pending_d = stimer_pending_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            audf_q           <= '0;
            audc_q           <= '0;
            audctl_q         <= 8'd0;
            stimer_pending_q <= 1'b0;
        end else begin
            audf_q           <= audf_d;
            audc_q           <= audc_d;
            audctl_q         <= audctl_d;
            stimer_pending_q <= stimer_pending_d;
        end
    end

    assign base_s    = audctl_q[CLK15] ? enable_15 : enable_64;
    assign join_s    = {audctl_q[JOIN34], audctl_q[JOIN12]};
    assign fast_s    = {audctl_q[FAST3], audctl_q[FAST1]};
    assign tick_s    = {base_s, (fast_s[1] ? ce : base_s), base_s, (fast_s[0] ? ce : base_s)};
    assign ev_s      = tick_s & {4{ce}};
    assign stim_s    = ce & stimer_pending_q;

    // Pair p couples channel 2p (low byte, borrow source) with 2p+1 (high bits).
    for (genvar p = 0; p < 2; p++) begin : g_pair
        localparam int LO = 2 * p;
        localparam int HI = 2 * p + 1;

        assign jz_s[p]       = zero_s[LO] & zero_s[HI];
        assign jrv_s[p]      = joined_reload(audf_q[HI], audf_q[LO], fast_s[p]);
        assign lo_under_s[p] = join_s[p] ? jz_s[p] : zero_s[LO];

        assign wide_s[LO] = ~join_s[p];
        assign load_s[LO] = stim_s | (ev_s[LO] & lo_under_s[p]);
        assign dec_s[LO]  = ev_s[LO] & ~lo_under_s[p];
        assign rv_s[LO]   = join_s[p] ? {1'b0, jrv_s[p][7:0]} : single_reload(audf_q[LO], fast_s[p]);

        assign wide_s[HI] = 1'b1;
        assign load_s[HI] = stim_s | (join_s[p] ? (ev_s[LO] & jz_s[p]) : (ev_s[HI] & zero_s[HI]));
        assign dec_s[HI]  = join_s[p] ? (ev_s[LO] & ~jz_s[p] & zero_s[LO])
                                      : (ev_s[HI] & ~zero_s[HI]);
        assign rv_s[HI]   = join_s[p] ? jrv_s[p][16:8] : single_reload(audf_q[HI], 1'b0);

        assign pulse_s[LO] = ~join_s[p] & ev_s[LO] & zero_s[LO] & ~stimer_pending_q & ~reset;
        assign pulse_s[HI] = (join_s[p] ? (ev_s[LO] & jz_s[p]) : (ev_s[HI] & zero_s[HI]))
                             & ~stimer_pending_q & ~reset;
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        pokey_timer_channel u_chan (
            .clk          (clk),
            .reset        (reset),
            .load_i       (load_s[i]),
            .dec_i        (dec_s[i]),
            .wide_i       (wide_s[i]),
            .reload_val_i (rv_s[i]),
            .zero_o       (zero_s[i])
        );

        assign noise_select[3*i +: 3] = audc_q[i][7:5];
        assign vol_only[i]            = audc_q[i][4];
        assign volume[4*i +: 4]       = audc_q[i][3:0];
    end

    assign pulse      = pulse_s;
    assign sync_reset = stimer_pending_q;
    assign audctl     = audctl_q;

endmodule

// File: tb/tb_pokey_timer_ctrl.sv
// Directed self-checking bench for pokey_timer_ctrl.
module tb_pokey_timer_ctrl;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        enable_64;
    logic        enable_15;
    logic        wr_en;
    logic [3:0]  addr;
    logic [7:0]  wr_data;
    logic [3:0]  pulse;
    logic [11:0] noise_select;
    logic [3:0]  vol_only;
    logic [15:0] volume;
    logic        sync_reset;
    logic [7:0]  audctl;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  pulse_smp;
    logic        sr_smp;

    pokey_timer_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .enable_64    (enable_64),
        .enable_15    (enable_15),
        .wr_en        (wr_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .pulse        (pulse),
        .noise_select (noise_select),
        .vol_only     (vol_only),
        .volume       (volume),
        .sync_reset   (sync_reset),
        .audctl       (audctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk cycle: drive inputs, sample combinational pulse at negedge, then take the edge.
    task automatic drive(input logic c, input logic e64, input logic e15, input logic w,
                         input logic [3:0] a, input logic [7:0] d);
        ce = c; enable_64 = e64; enable_15 = e15; wr_en = w; addr = a; wr_data = d;
        @(negedge clk);
        pulse_smp = pulse;
        sr_smp    = sync_reset;
        @(posedge clk);
        #1;
        ce = 1'b0; enable_64 = 1'b0; enable_15 = 1'b0; wr_en = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        drive(1'b0, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    // STIMER write followed by a ce-only cycle that consumes it.
    task automatic resync();
        write_reg(4'd9, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; enable_64 = 1'b0; enable_15 = 1'b0;
        wr_en = 1'b0; addr = 4'd0; wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pulse", pulse, 4'h0);
        check("rst_ns", noise_select, 12'h000);
        check("rst_vo", vol_only, 4'h0);
        check("rst_vol", volume, 16'h0000);
        check("rst_sr", sync_reset, 1'b0);
        check("rst_audctl", audctl, 8'h00);

        // reset with write and ce in the same cycle
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 8'hFF);
        check("rst_wr_pulse", pulse_smp, 4'h0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        check("rst_wr_vol", volume, 16'h0000);
        check("rst_wr_ns", noise_select, 12'h000);
        check("rst_wr_vo", vol_only, 4'h0);

        write_reg(4'd1, 8'hA5);
        check("ns_c1", noise_select, 12'h005);
        check("vo_c1", vol_only, 4'h0);
        check("vol_c1", volume, 16'h0005);
        write_reg(4'd7, 8'h3C);
        check("ns_c4", noise_select, 12'h205);
        check("vo_c4", vol_only, 4'h8);
        check("vol_c4", volume, 16'hC005);
        write_reg(4'd10, 8'hFF);
        check("ign_ns", noise_select, 12'h205);
        check("ign_vol", volume, 16'hC005);
        check("ign_audctl", audctl, 8'h00);
        write_reg(4'd8, 8'h81);
        check("audctl_wr", audctl, 8'h81);

        // enable_64 base clock, AUDF1=3, with STIMER suppression on the consuming ce
        write_reg(4'd8, 8'h00);
        write_reg(4'd0, 8'h03);
        write_reg(4'd9, 8'h00);
        check("stim_pend", sync_reset, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        check("stim_sr_at_ce", sr_smp, 1'b1);
        check("stim_suppress", pulse_smp, 4'h0);
        check("stim_cleared", sync_reset, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
            check("b64_tick", pulse_smp[0], (i % 4) == 3);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            check("b64_idle", pulse_smp, 4'h0);
        end

        // enable_15 base clock, AUDF1=1: pulse every 2nd enable_15 only
        write_reg(4'd8, 8'h01);
        write_reg(4'd0, 8'h01);
        resync();
        for (int i = 0; i < 8; i++) begin
            if ((i % 2) == 0) begin
                drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
                check("b15_e64", pulse_smp[0], 1'b0);
            end else begin
                drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00);
                check("b15_e15", pulse_smp[0], (i % 4) == 3);
            end
        end

        // ch1 on machine clock
        write_reg(4'd8, 8'h40);
        write_reg(4'd0, 8'h00);
        resync();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            check("fast_f0", pulse_smp[0], (i % 4) == 3);
        end
        write_reg(4'd0, 8'h10);
        resync();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            check("fast_f10", pulse_smp[0], (i % 20) == 19);
        end

        // ch1+2 joined on machine clock: period 0x0100+7 = 263
        write_reg(4'd8, 8'h50);
        write_reg(4'd0, 8'h00);
        write_reg(4'd2, 8'h01);
        resync();
        for (int i = 0; i < 600; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            check("join12", pulse_smp, ((i % 263) == 262) ? 4'h2 : 4'h0);
        end

        // ch3+4 joined on machine clock, AUDF3=AUDF4=0: period 7
        write_reg(4'd8, 8'h28);
        write_reg(4'd4, 8'h00);
        write_reg(4'd6, 8'h00);
        resync();
        for (int i = 0; i < 21; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            check("join34", pulse_smp[3:2], ((i % 7) == 6) ? 2'b10 : 2'b00);
        end

        // STIMER mid-count, written on a ce edge
        write_reg(4'd8, 8'h00);
        write_reg(4'd0, 8'h04);
        resync();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
            check("mid_pre", pulse_smp[0], 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 8'h00);
        check("mid_wr_pulse", pulse_smp[0], 1'b0);
        check("mid_pend", sync_reset, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        check("mid_sr_at_ce", sr_smp, 1'b1);
        check("mid_suppress", pulse_smp[0], 1'b0);
        check("mid_cleared", sync_reset, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
            check("mid_post", pulse_smp[0], i == 4);
        end

        // AUDF1 5->2 mid-period, then a write landing on a reload
        write_reg(4'd0, 8'h05);
        resync();
        for (int i = 1; i <= 23; i++) begin
            drive(1'b1, 1'b1, 1'b0, (i == 2) || (i == 12), 4'd0, (i == 2) ? 8'h02 : 8'h07);
            check("audf_chg", pulse_smp[0],
                  (i == 6) || (i == 9) || (i == 12) || (i == 15) || (i == 23));
        end

        // reset mid-count discards everything
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        check("rst2_pulse", pulse_smp, 4'h0);
        reset = 1'b0;
        check("rst2_vol", volume, 16'h0000);
        check("rst2_audctl", audctl, 8'h00);
        check("rst2_sr", sync_reset, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        check("rst2_cnt0", pulse_smp, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
